seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seg_scan_driver.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver with PWM brightness.
// Inputs are captured once per frame; all outputs are registered.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BRIGHT_W    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] DIGITS,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    input  logic [BRIGHT_W-1:0]     BRIGHTNESS,
    output logic [NUM_DIGITS-1:0]   SEG_ANODE,
    output logic [6:0]              SEG_CATHODE,
    output logic                    SEG_DP,
    output logic                    FRAME_TICK
);

    localparam int LEVELS = 1 << BRIGHT_W;
    localparam int SUB    = REFRESH_DIV / LEVELS;
    localparam int SUB_W  = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int SLOT_W = $clog2(NUM_DIGITS);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("seg_scan_driver: NUM_DIGITS must be 2..8");
    end
    if (REFRESH_DIV < LEVELS || (REFRESH_DIV % LEVELS) != 0) begin : g_bad_div
        $error("seg_scan_driver: REFRESH_DIV must be a multiple of 2**BRIGHT_W");
    end

    logic [SUB_W-1:0]        sub_cnt;
    logic [BRIGHT_W-1:0]     phase;
    logic [SLOT_W-1:0]       slot;
    logic                    sub_last;
    logic                    phase_last;
    logic                    slot_last;
    logic                    frame_end;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_en;
    logic [BRIGHT_W-1:0]     sh_bright;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   anode_next;

    // Active-low hex decode, bit 0 = segment a ... bit 6 = segment g
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign sub_last   = (sub_cnt == SUB_W'(SUB - 1));
    assign phase_last = (phase == '1);
    assign slot_last  = (slot == SLOT_W'(NUM_DIGITS - 1));
    assign frame_end  = sub_last && phase_last && slot_last;

    // Cascaded sub / phase / slot counters; phase wraps on its own width
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_cnt <= '0;
            phase   <= '0;
            slot    <= '0;
        end else begin
            sub_cnt <= sub_last ? '0 : sub_cnt + 1'b1;
            if (sub_last) begin
                phase <= phase + 1'b1;
                if (phase_last) begin
                    slot <= slot_last ? '0 : slot + 1'b1;
                end
            end
        end
    end

    // Shadow copies of the inputs, refreshed only at the frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_en     <= '0;
            sh_bright <= '0;
        end else if (frame_end) begin
            sh_digits <= DIGITS;
            sh_dp     <= DP;
            sh_en     <= DIGIT_EN;
            sh_bright <= BRIGHTNESS;
        end
    end

    // Select the current digit's shadow data and decide whether it is lit
    always_comb begin
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_en     = 1'b0;
        anode_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot == SLOT_W'(i)) begin
                cur_nib = sh_digits[4*i +: 4];
                cur_dp  = sh_dp[i];
                cur_en  = sh_en[i];
            end
        end
        lit = cur_en && (phase < sh_bright);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_next[i] = !(lit && (slot == SLOT_W'(i)));
        end
    end

    // Registered display outputs and frame pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            SEG_ANODE   <= '1;
            SEG_CATHODE <= 7'h7F;
            SEG_DP      <= 1'b1;
            FRAME_TICK  <= 1'b0;
        end else begin
            SEG_ANODE   <= anode_next;
            SEG_CATHODE <= lit ? hex7(cur_nib) : 7'h7F;
            SEG_DP      <= lit ? ~cur_dp : 1'b1;
            FRAME_TICK  <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver (4 digits, 16-cycle slots, 2-bit PWM).
// A frame-position model predicts every output cycle.
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int RD    = 16;
    localparam int BW    = 2;
    localparam int FRAME = ND * RD;
    localparam int SUBC  = RD / (1 << BW);

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   digits;
    logic [3:0]    dp;
    logic [3:0]    digit_en;
    logic [1:0]    brightness;
    logic [3:0]    seg_anode;
    logic [6:0]    seg_cathode;
    logic          seg_dp;
    logic          frame_tick;

    seg_scan_driver #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .BRIGHT_W   (BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .DIGITS     (digits),
        .DP         (dp),
        .DIGIT_EN   (digit_en),
        .BRIGHTNESS (brightness),
        .SEG_ANODE  (seg_anode),
        .SEG_CATHODE(seg_cathode),
        .SEG_DP     (seg_dp),
        .FRAME_TICK (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] ca;
        logic       dp;
        logic       tk;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         passed = 0;
    int         cyc    = 0;
    logic [6:0] hex_tab[16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] sh_dig[ND];
    logic       sh_dp[ND];
    logic       sh_en[ND];
    logic [1:0] sh_br;

    // Reference model: cyc is the position inside the frame
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            if (reset) begin
                cyc = 0;
                sh_br = '0;
                for (int i = 0; i < ND; i++) begin
                    sh_dig[i] = '0;
                    sh_dp[i]  = 1'b0;
                    sh_en[i]  = 1'b0;
                end
                e = '{an: 4'hF, ca: 7'h7F, dp: 1'b1, tk: 1'b0};
            end else begin
                int         s;
                int         ph;
                logic       lit;
                logic [3:0] one;
                s   = cyc / RD;
                ph  = (cyc % RD) / SUBC;
                lit = sh_en[s] && (ph < int'(sh_br));
                one = 4'b0001 << s;
                e.an = lit ? ~one : 4'hF;
                e.ca = lit ? hex_tab[sh_dig[s]] : 7'h7F;
                e.dp = lit ? ~sh_dp[s] : 1'b1;
                e.tk = (cyc == FRAME - 1);
                if (cyc == FRAME - 1) begin
                    sh_br = brightness;
                    for (int i = 0; i < ND; i++) begin
                        sh_dig[i] = digits[4*i +: 4];
                        sh_dp[i]  = dp[i];
                        sh_en[i]  = digit_en[i];
                    end
                end
                cyc = (cyc + 1) % FRAME;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: every cycle's outputs are popped against the model
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL queue_empty t=%0t got 0 entries, need 1", $time);
            end else begin
                e = exp_q.pop_front();
                if (seg_anode === e.an && seg_cathode === e.ca &&
                    seg_dp === e.dp && frame_tick === e.tk) begin
                    passed++;
                end else begin
                    $display("FAIL outputs t=%0t got an=%b ca=%b dp=%b tk=%b need an=%b ca=%b dp=%b tk=%b",
                             $time, seg_anode, seg_cathode, seg_dp, frame_tick,
                             e.an, e.ca, e.dp, e.tk);
                end
            end
            checks++;
            if ($countones(~seg_anode) <= 1) begin
                passed++;
            end else begin
                $display("FAIL onehot t=%0t got an=%b, need at most one low", $time, seg_anode);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        digits     = 16'h1234;
        dp         = 4'h0;
        digit_en   = 4'hF;
        brightness = 2'd3;
        step(3);
        reset = 1'b0;
        step(3 * FRAME);

        brightness = 2'd0;
        step(2 * FRAME);

        brightness = 2'd3;
        step(FRAME + 20);
        digits = 16'hFFFF;
        step(2 * FRAME);

        digits   = 16'h1234;
        digit_en = 4'b0101;
        step(2 * FRAME);

        digit_en = 4'hF;
        dp       = 4'b0010;
        step(2 * FRAME);

        begin
            int guard = 0;
            while (cyc != 30 && guard < 2 * FRAME) begin
                step(1);
                guard++;
            end
            checks++;
            if (cyc == 30) passed++;
            else $display("FAIL align got cyc=%0d, need 30", cyc);
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(3 * FRAME);

        for (int k = 0; k < 20 * FRAME; k++) begin
            if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 15) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
            reset = ($urandom_range(0, 499) == 0);
            step(1);
        end
        reset = 1'b0;
        step(2 * FRAME);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain got %0d entries left, need 0", exp_q.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
